// File: rtl/rename_regfile_ckpt_if.sv
// rename_regfile_ckpt_if: dispatch, commit and checkpoint signals between the pipeline and the rename register file.
interface rename_regfile_ckpt_if #(
   parameter int XLEN          = 32,
   parameter int REG_CNT_WIDTH = 5,
   parameter int ROB_ID_WIDTH  = 3,
   parameter int CKPT_ID_WIDTH = 2
);
   logic                     rdy;
   logic                     flush;
   logic                     stall;
   logic                     dec_valid;
   logic                     dec_writes_rd;
   logic [REG_CNT_WIDTH-1:0] dec_rd;
   logic [REG_CNT_WIDTH-1:0] dec_rs1;
   logic [REG_CNT_WIDTH-1:0] dec_rs2;
   logic [ROB_ID_WIDTH-1:0]  dec_rob_id;
   logic                     dec_ckpt_req;
   logic                     ckpt_avail;
   logic [CKPT_ID_WIDTH-1:0] ckpt_id;
   logic                     cm_valid;
   logic [REG_CNT_WIDTH-1:0] cm_rd;
   logic [XLEN-1:0]          cm_val;
   logic [ROB_ID_WIDTH-1:0]  cm_rob_id;
   logic                     rel_valid;
   logic                     rec_valid;
   logic [CKPT_ID_WIDTH-1:0] rec_ckpt_id;
   logic [XLEN-1:0]          rs1_val;
   logic [ROB_ID_WIDTH:0]    rs1_dep;
   logic [XLEN-1:0]          rs2_val;
   logic [ROB_ID_WIDTH:0]    rs2_dep;
   modport master (
      output rdy, flush, stall, dec_valid, dec_writes_rd, dec_rd, dec_rs1, dec_rs2, dec_rob_id,
             dec_ckpt_req, cm_valid, cm_rd, cm_val, cm_rob_id, rel_valid, rec_valid, rec_ckpt_id,
      input  ckpt_avail, ckpt_id, rs1_val, rs1_dep, rs2_val, rs2_dep
   );
   modport slave (
      input  rdy, flush, stall, dec_valid, dec_writes_rd, dec_rd, dec_rs1, dec_rs2, dec_rob_id,
             dec_ckpt_req, cm_valid, cm_rd, cm_val, cm_rob_id, rel_valid, rec_valid, rec_ckpt_id,
      output ckpt_avail, ckpt_id, rs1_val, rs1_dep, rs2_val, rs2_dep
   );
endinterface

// File: rtl/rename_regfile_ckpt.sv
// rename_regfile_ckpt: arch register file + rename table with a ring of branch checkpoints.
// Define RF_BYPASS_EN to forward a same-cycle commit onto the operand reads.
module rename_regfile_ckpt #(
   parameter int XLEN          = 32,
   parameter int REG_CNT_WIDTH = 5,
   parameter int ROB_ID_WIDTH  = 3,
   parameter int CKPT_ID_WIDTH = 2
) (
   input logic clk,
   input logic rst,
   rename_regfile_ckpt_if.slave bus
);
   localparam int REG_CNT  = 2**REG_CNT_WIDTH;
   localparam int NUM_CKPT = 2**CKPT_ID_WIDTH;
   localparam int DEP_W    = ROB_ID_WIDTH + 1;
`ifdef RF_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   typedef logic [DEP_W-1:0] dep_t;
   typedef logic [REG_CNT_WIDTH-1:0] reg_t;
   typedef logic [CKPT_ID_WIDTH-1:0] cid_t;
   localparam dep_t NONE = '1;
   logic [XLEN-1:0] val_q [REG_CNT];
   dep_t dep_q [REG_CNT];
   dep_t dep_clr [REG_CNT];
   dep_t dep_ren [REG_CNT];
   dep_t dep_n [REG_CNT];
   dep_t ckpt_q [NUM_CKPT][REG_CNT];
   dep_t ckpt_clr [NUM_CKPT][REG_CNT];
   dep_t ckpt_n [NUM_CKPT][REG_CNT];
   logic [NUM_CKPT-1:0] valid_q, valid_n;
   cid_t head_q, head_n, tail_q, tail_n;
   logic cm_en, ren_en, alloc;
   dep_t cm_tag;
   assign cm_en  = bus.cm_valid && bus.cm_rd != '0;
   assign cm_tag = {1'b0, bus.cm_rob_id};
   assign ren_en = bus.dec_valid && !bus.stall && bus.dec_writes_rd && bus.dec_rd != '0;
   assign alloc  = bus.dec_valid && !bus.stall && bus.dec_ckpt_req && bus.ckpt_avail;
   assign bus.ckpt_avail = !valid_q[tail_q];
   assign bus.ckpt_id    = tail_q;
   // a commit only clears a dependency that still names the committing tag
   always_comb begin
      for (int r = 0; r < REG_CNT; r++) begin
         dep_clr[r] = (cm_en && bus.cm_rd == reg_t'(r) && dep_q[r] == cm_tag) ? NONE : dep_q[r];
         for (int c = 0; c < NUM_CKPT; c++)
            ckpt_clr[c][r] = (cm_en && bus.cm_rd == reg_t'(r) && ckpt_q[c][r] == cm_tag) ? NONE : ckpt_q[c][r];
      end
      dep_ren = dep_clr;
      if (ren_en) dep_ren[bus.dec_rd] = {1'b0, bus.dec_rob_id};
   end
   always_comb begin
      bus.rs1_val = bus.dec_rs1 == '0 ? '0 : (BYP && cm_en && bus.cm_rd == bus.dec_rs1) ? bus.cm_val : val_q[bus.dec_rs1];
      bus.rs2_val = bus.dec_rs2 == '0 ? '0 : (BYP && cm_en && bus.cm_rd == bus.dec_rs2) ? bus.cm_val : val_q[bus.dec_rs2];
      bus.rs1_dep = bus.dec_rs1 == '0 ? NONE : BYP ? dep_clr[bus.dec_rs1] : dep_q[bus.dec_rs1];
      bus.rs2_dep = bus.dec_rs2 == '0 ? NONE : BYP ? dep_clr[bus.dec_rs2] : dep_q[bus.dec_rs2];
   end
   always_comb begin
      dep_n   = dep_ren;
      ckpt_n  = ckpt_clr;
      valid_n = valid_q;
      head_n  = head_q;
      tail_n  = tail_q;
      if (bus.flush) begin
         for (int r = 0; r < REG_CNT; r++) dep_n[r] = NONE;
         valid_n = '0;
         head_n  = '0;
         tail_n  = '0;
      end else if (bus.rec_valid) begin
         dep_n = ckpt_clr[bus.rec_ckpt_id];
         // slots younger than the restored one, measured from head
         for (int c = 0; c < NUM_CKPT; c++)
            if (cid_t'(cid_t'(c) - head_q) > cid_t'(bus.rec_ckpt_id - head_q)) valid_n[c] = 1'b0;
         tail_n = bus.rec_ckpt_id + 1'b1;
         if (bus.rel_valid) begin
            valid_n[head_q] = 1'b0;
            head_n = head_q + 1'b1;
         end
      end else begin
         if (alloc) begin
            ckpt_n[tail_q]  = dep_ren;
            valid_n[tail_q] = 1'b1;
            tail_n = tail_q + 1'b1;
         end
         if (bus.rel_valid) begin
            valid_n[head_q] = 1'b0;
            head_n = head_q + 1'b1;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < REG_CNT; r++) begin
            val_q[r] <= '0;
            dep_q[r] <= NONE;
            for (int c = 0; c < NUM_CKPT; c++) ckpt_q[c][r] <= NONE;
         end
         valid_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
      end else if (bus.rdy) begin
         if (cm_en) val_q[bus.cm_rd] <= bus.cm_val;
         dep_q   <= dep_n;
         ckpt_q  <= ckpt_n;
         valid_q <= valid_n;
         head_q  <= head_n;
         tail_q  <= tail_n;
      end
   end
endmodule

// File: tb/tb_rename_regfile_ckpt.sv
// tb_rename_regfile_ckpt: directed vector table plus hand sequences for hold, stall, x0 and rename-vs-commit.
module tb_rename_regfile_ckpt;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;
   rename_regfile_ckpt_if bus ();
   rename_regfile_ckpt dut (.clk(clk), .rst(rst), .bus(bus));
`ifdef RF_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   localparam int FL = 64, DV = 32, WR = 16, CR = 8, CV = 4, RL = 2, RC = 1;
   typedef struct {
      int ctl; int rd; int rs1; int rs2; int tag; int crd; int cval; int ctag; int rid;
      int e1v; int e1d; int e2v; int e2d; int eav; int eid;
   } vec_t;
   vec_t vt [38];
   int total = 0;
   int bad = 0;
   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask
   task automatic idle();
      bus.rdy = 1'b1; bus.flush = 1'b0; bus.stall = 1'b0; bus.dec_valid = 1'b0; bus.dec_writes_rd = 1'b0;
      bus.dec_rd = '0; bus.dec_rs1 = '0; bus.dec_rs2 = '0; bus.dec_rob_id = '0; bus.dec_ckpt_req = 1'b0;
      bus.cm_valid = 1'b0; bus.cm_rd = '0; bus.cm_val = '0; bus.cm_rob_id = '0;
      bus.rel_valid = 1'b0; bus.rec_valid = 1'b0; bus.rec_ckpt_id = '0;
   endtask
   task automatic drive(vec_t v);
      idle();
      bus.flush = v.ctl[6]; bus.dec_valid = v.ctl[5]; bus.dec_writes_rd = v.ctl[4]; bus.dec_ckpt_req = v.ctl[3];
      bus.cm_valid = v.ctl[2]; bus.rel_valid = v.ctl[1]; bus.rec_valid = v.ctl[0];
      bus.dec_rd = 5'(v.rd); bus.dec_rs1 = 5'(v.rs1); bus.dec_rs2 = 5'(v.rs2); bus.dec_rob_id = 3'(v.tag);
      bus.cm_rd = 5'(v.crd); bus.cm_val = v.cval; bus.cm_rob_id = 3'(v.ctag); bus.rec_ckpt_id = 2'(v.rid);
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   initial begin
      vt[0]  = '{0,        0, 5, 0, 0, 0, 0,        0, 0, 0,        15, 0, 15, 1, 0};
      vt[1]  = '{DV|WR,    5, 5, 0, 3, 0, 0,        0, 0, 0,        15, 0, 15, 1, 0};
      vt[2]  = '{0,        0, 5, 0, 0, 0, 0,        0, 0, 0,        3,  0, 15, 1, 0};
      vt[3]  = '{CV,       0, 7, 0, 0, 5, 'hDEAD,   3, 0, 0,        15, 0, 15, 1, 0};
      vt[4]  = '{0,        0, 5, 0, 0, 0, 0,        0, 0, 'hDEAD,   15, 0, 15, 1, 0};
      vt[5]  = '{DV|WR,    5, 5, 0, 3, 0, 0,        0, 0, 'hDEAD,   15, 0, 15, 1, 0};
      vt[6]  = '{CV,       0, 6, 0, 0, 5, 'hBEEF,   2, 0, 0,        15, 0, 15, 1, 0};
      vt[7]  = '{0,        0, 5, 0, 0, 0, 0,        0, 0, 'hBEEF,   3,  0, 15, 1, 0};
      vt[8]  = '{DV|CR,    0, 0, 0, 0, 0, 0,        0, 0, 0,        15, 0, 15, 1, 0};
      vt[9]  = '{DV|CR,    0, 0, 0, 0, 0, 0,        0, 0, 0,        15, 0, 15, 1, 1};
      vt[10] = '{DV|CR,    0, 0, 0, 0, 0, 0,        0, 0, 0,        15, 0, 15, 1, 2};
      vt[11] = '{DV|CR,    0, 0, 0, 0, 0, 0,        0, 0, 0,        15, 0, 15, 1, 3};
      vt[12] = '{DV|CR,    0, 0, 0, 0, 0, 0,        0, 0, 0,        15, 0, 15, 0, 0};
      vt[13] = '{RL,       0, 0, 0, 0, 0, 0,        0, 0, 0,        15, 0, 15, 0, 0};
      vt[14] = '{0,        0, 0, 0, 0, 0, 0,        0, 0, 0,        15, 0, 15, 1, 0};
      vt[15] = '{DV|CR,    0, 0, 0, 0, 0, 0,        0, 0, 0,        15, 0, 15, 1, 0};
      vt[16] = '{0,        0, 0, 0, 0, 0, 0,        0, 0, 0,        15, 0, 15, 0, 1};
      vt[17] = '{FL,       0, 5, 0, 0, 0, 0,        0, 0, 'hBEEF,   3,  0, 15, 0, 1};
      vt[18] = '{0,        0, 5, 0, 0, 0, 0,        0, 0, 'hBEEF,   15, 0, 15, 1, 0};
      vt[19] = '{DV|WR|CR, 7, 7, 0, 1, 0, 0,        0, 0, 0,        15, 0, 15, 1, 0};
      vt[20] = '{DV|WR|CR, 7, 7, 0, 2, 0, 0,        0, 0, 0,        1,  0, 15, 1, 1};
      vt[21] = '{0,        0, 7, 0, 0, 0, 0,        0, 0, 0,        2,  0, 15, 1, 2};
      vt[22] = '{RC,       0, 7, 0, 0, 0, 0,        0, 0, 0,        2,  0, 15, 1, 2};
      vt[23] = '{0,        0, 7, 0, 0, 0, 0,        0, 0, 0,        1,  0, 15, 1, 1};
      vt[24] = '{DV|WR|CR, 9, 9, 0, 4, 0, 0,        0, 0, 0,        15, 0, 15, 1, 1};
      vt[25] = '{CV,       0, 7, 0, 0, 9, 'h99,     4, 0, 0,        1,  0, 15, 1, 2};
      vt[26] = '{DV|WR,    9, 9, 0, 5, 0, 0,        0, 0, 'h99,     15, 0, 15, 1, 2};
      vt[27] = '{RC,       0, 9, 0, 0, 0, 0,        0, 1, 'h99,     5,  0, 15, 1, 2};
      vt[28] = '{0,        0, 9, 7, 0, 0, 0,        0, 0, 'h99,     15, 0, 1,  1, 2};
      vt[29] = '{DV|WR,    6, 6, 0, 5, 0, 0,        0, 0, 0,        15, 0, 15, 1, 2};
      vt[30] = '{CV,       0, 6, 0, 0, 6, 'h11,     5, 0, BYP ? 'h11 : 0, BYP ? 15 : 5, 0, 15, 1, 2};
      vt[31] = '{0,        0, 6, 0, 0, 0, 0,        0, 0, 'h11,     15, 0, 15, 1, 2};
      vt[32] = '{DV|CR|RL, 0, 0, 0, 0, 0, 0,        0, 0, 0,        15, 0, 15, 1, 2};
      vt[33] = '{0,        0, 0, 0, 0, 0, 0,        0, 0, 0,        15, 0, 15, 1, 3};
      vt[34] = '{DV|CR|RL, 0, 0, 0, 0, 0, 0,        0, 0, 0,        15, 0, 15, 1, 3};
      vt[35] = '{0,        0, 0, 0, 0, 0, 0,        0, 0, 0,        15, 0, 15, 1, 0};
      vt[36] = '{RC,       0, 0, 0, 0, 0, 0,        0, 2, 0,        15, 0, 15, 1, 0};
      vt[37] = '{0,        0, 6, 7, 0, 0, 0,        0, 0, 'h11,     15, 0, 1,  1, 3};
      idle();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      for (int i = 0; i < 38; i++) begin
         drive(vt[i]);
         @(negedge clk);
         chk($sformatf("v%0d rs1_val", i), bus.rs1_val, vt[i].e1v);
         chk($sformatf("v%0d rs1_dep", i), 32'(bus.rs1_dep), vt[i].e1d);
         chk($sformatf("v%0d rs2_val", i), bus.rs2_val, vt[i].e2v);
         chk($sformatf("v%0d rs2_dep", i), 32'(bus.rs2_dep), vt[i].e2d);
         chk($sformatf("v%0d ckpt_avail", i), 32'(bus.ckpt_avail), vt[i].eav);
         chk($sformatf("v%0d ckpt_id", i), 32'(bus.ckpt_id), vt[i].eid);
         step();
      end
      // rdy low: rename, commit and flush must all be held off
      idle();
      bus.rdy = 1'b0; bus.flush = 1'b1; bus.dec_valid = 1'b1; bus.dec_writes_rd = 1'b1; bus.dec_rd = 5'd10;
      bus.dec_rob_id = 3'd7; bus.cm_valid = 1'b1; bus.cm_rd = 5'd6; bus.cm_val = 32'h22;
      step();
      idle();
      bus.dec_rs1 = 5'd10; bus.dec_rs2 = 5'd6;
      @(negedge clk);
      chk("hold rs1_dep", 32'(bus.rs1_dep), 32'hF);
      chk("hold rs2_val", bus.rs2_val, 32'h11);
      chk("hold ckpt_id", 32'(bus.ckpt_id), 32'd3);
      // stall: dec_* ignored, including the checkpoint request
      idle();
      bus.stall = 1'b1; bus.dec_valid = 1'b1; bus.dec_writes_rd = 1'b1; bus.dec_rd = 5'd10;
      bus.dec_rob_id = 3'd7; bus.dec_ckpt_req = 1'b1;
      step();
      idle();
      bus.dec_rs1 = 5'd10;
      @(negedge clk);
      chk("stall rs1_dep", 32'(bus.rs1_dep), 32'hF);
      chk("stall ckpt_id", 32'(bus.ckpt_id), 32'd3);
      // x0 neither renamed nor written
      idle();
      bus.dec_valid = 1'b1; bus.dec_writes_rd = 1'b1; bus.dec_rd = 5'd0; bus.dec_rob_id = 3'd1;
      bus.cm_valid = 1'b1; bus.cm_rd = 5'd0; bus.cm_val = 32'h5; bus.cm_rob_id = 3'd1;
      step();
      idle();
      @(negedge clk);
      chk("x0 rs1_val", bus.rs1_val, 32'h0);
      chk("x0 rs1_dep", 32'(bus.rs1_dep), 32'hF);
      // rename beats a same-cycle commit clear of the same register
      idle();
      bus.dec_valid = 1'b1; bus.dec_writes_rd = 1'b1; bus.dec_rd = 5'd10; bus.dec_rob_id = 3'd6;
      step();
      idle();
      bus.dec_valid = 1'b1; bus.dec_writes_rd = 1'b1; bus.dec_rd = 5'd10; bus.dec_rob_id = 3'd7;
      bus.cm_valid = 1'b1; bus.cm_rd = 5'd10; bus.cm_val = 32'h33; bus.cm_rob_id = 3'd6;
      step();
      idle();
      bus.dec_rs1 = 5'd10;
      @(negedge clk);
      chk("ren_vs_cm rs1_val", bus.rs1_val, 32'h33);
      chk("ren_vs_cm rs1_dep", 32'(bus.rs1_dep), 32'h7);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
